// File: rtl/io_pkg.sv
// Shared definitions for the programmed-I/O flag unit: the output FSM
// state encoding and the default data width and output timeout.
package io_pkg;

  typedef enum logic {
    IO_IDLE = 1'b0,
    IO_SEND = 1'b1
  } io_state_e;

  localparam int IO_DATA_W      = 8;
  localparam int IO_OUT_TIMEOUT = 255;
  // Wide enough for any OUT_TIMEOUT in 1..65535.
  localparam int IO_CNT_W       = 16;

endpackage

// File: rtl/io_out_fsm.sv
// Output-device handshake: holds OUT data in outr, drives out_valid while
// sending, times out a silent device and keeps the sticky out_err flag.
// FGO itself lives in the top; this block only reports set/clear pulses.
module io_out_fsm
  import io_pkg::*;
#(
  parameter int DATA_W      = IO_DATA_W,
  parameter int OUT_TIMEOUT = IO_OUT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_out,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              sFO,
  input  logic              rFO,
  input  logic              out_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              fgo_set,
  output logic              fgo_clr
);

  localparam logic [IO_CNT_W-1:0] CNT_LAST = IO_CNT_W'(OUT_TIMEOUT - 1);

  io_state_e           state_q;
  logic [IO_CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0]   outr_q;
  logic                err_q;
  logic                sending;
  logic                at_last;
  logic                start;
  logic                done;
  logic                timeout;

  // sFO aborts a transfer and also blocks a new one in the same cycle.
  assign sending = (state_q == IO_SEND);
  assign at_last = (cnt_q == CNT_LAST);
  assign start   = ~sending & io_out & ~sFO;
  assign done    = sending & ~sFO & (out_ack | at_last);
  assign timeout = sending & ~sFO & ~out_ack & at_last;

  assign fgo_clr   = start;
  assign fgo_set   = done;
  assign out_valid = sending;
  assign out_data  = outr_q;
  assign out_err   = err_q;

  // Output FSM, timeout counter, data latch and sticky timeout error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IO_IDLE;
      cnt_q   <= '0;
      outr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // A fresh timeout is kept even if rFO arrives in the same cycle.
      if (timeout) begin
        err_q <= 1'b1;
      end else if (rFO) begin
        err_q <= 1'b0;
      end

      if (sFO) begin
        state_q <= IO_IDLE;
      end else begin
        case (state_q)
          IO_IDLE: begin
            if (io_out) begin
              outr_q  <= io_wdata;
              cnt_q   <= '0;
              state_q <= IO_SEND;
            end
          end
          IO_SEND: begin
            if (done) begin
              state_q <= IO_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= IO_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/io_flag_unit.sv
// Programmed-I/O responder: input register and FGI, output register and
// FGO (via io_out_fsm), and the interrupt-enable/request logic.
// Build option: define IO_IRQ_EN to include the interrupt logic; without it
// IEN and irq are tied low and ION/IOF/irq_ack are ignored.
module io_flag_unit
  import io_pkg::*;
#(
  parameter int DATA_W      = IO_DATA_W,
  parameter int OUT_TIMEOUT = IO_OUT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rFI,
  input  logic              rFO,
  input  logic              sFO,
  input  logic              ION,
  input  logic              IOF,
  input  logic              io_in,
  input  logic              io_out,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ack,
  output logic              FGI,
  output logic              FGO,
  output logic              IEN,
  output logic              irq,
  input  logic              irq_ack,
  output logic              out_err
);

  logic [DATA_W-1:0] inpr_q;
  logic              fgi_q;
  logic              fgo_q;
  logic              fgo_set;
  logic              fgo_clr;
  logic              unused_io_in;

  // io_in is a pure read of inpr and has no side effect on the flags.
  assign unused_io_in = io_in;

  assign io_rdata = inpr_q;
  assign in_ready = ~fgi_q;
  assign FGI      = fgi_q;
  assign FGO      = fgo_q;

  io_out_fsm #(
    .DATA_W      (DATA_W),
    .OUT_TIMEOUT (OUT_TIMEOUT)
  ) u_out_fsm (
    .clk       (clk),
    .reset     (reset),
    .io_out    (io_out),
    .io_wdata  (io_wdata),
    .sFO       (sFO),
    .rFO       (rFO),
    .out_ack   (out_ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err),
    .fgo_set   (fgo_set),
    .fgo_clr   (fgo_clr)
  );

  // Input register and FGI; an accepted byte beats a same-cycle rFI.
  always_ff @(posedge clk) begin
    if (reset) begin
      inpr_q <= '0;
      fgi_q  <= 1'b0;
    end else if (in_valid && !fgi_q) begin
      inpr_q <= in_data;
      fgi_q  <= 1'b1;
    end else if (rFI) begin
      fgi_q <= 1'b0;
    end
  end

  // FGO with strobe priority: rFO, then sFO, then FSM start/finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      fgo_q <= 1'b1;
    end else if (rFO) begin
      fgo_q <= 1'b0;
    end else if (sFO) begin
      fgo_q <= 1'b1;
    end else if (fgo_clr) begin
      fgo_q <= 1'b0;
    end else if (fgo_set) begin
      fgo_q <= 1'b1;
    end
  end

`ifdef IO_IRQ_EN
  logic ien_q;
  logic irq_q;

  assign IEN = ien_q;
  assign irq = irq_q;

  // Interrupt enable and request; irq_ack dominates, irq holds until acked.
  always_ff @(posedge clk) begin
    if (reset) begin
      ien_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (irq_ack || IOF) begin
        ien_q <= 1'b0;
      end else if (ION) begin
        ien_q <= 1'b1;
      end

      if (irq_ack) begin
        irq_q <= 1'b0;
      end else if (ien_q && (fgi_q || fgo_q) && !irq_q) begin
        irq_q <= 1'b1;
      end
    end
  end
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = ION ^ IOF ^ irq_ack;
  assign IEN = 1'b0;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_flag_unit.sv
// Bench for io_flag_unit: directed vector table, hand-written interrupt
// sequence, then randomized strobes checked against a behavioural model.
module tb_io_flag_unit;

  localparam int DW  = 8;
  localparam int TMO = 4;
`ifdef IO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, rFI, rFO, sFO, ION, IOF, io_in, io_out;
  logic [DW-1:0] io_wdata, io_rdata, in_data, out_data;
  logic          in_valid, in_ready, out_valid, out_ack;
  logic          FGI, FGO, IEN, irq, irq_ack, out_err;

  int nchk = 0;
  int nerr = 0;

  io_flag_unit #(.DATA_W(DW), .OUT_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rFI(rFI), .rFO(rFO), .sFO(sFO),
    .ION(ION), .IOF(IOF), .io_in(io_in), .io_out(io_out),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ack(out_ack), .FGI(FGI), .FGO(FGO),
    .IEN(IEN), .irq(irq), .irq_ack(irq_ack), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: flags plus "a byte is being offered, for m_age cycles".
  logic [DW-1:0] m_inpr, m_outr;
  bit            m_fgi, m_fgo, m_ien, m_irq, m_err, m_send;
  int            m_age;

  task automatic model_step();
    logic [DW-1:0] n_inpr, n_outr;
    bit            n_fgi, n_fgo, n_ien, n_irq, n_err, n_send;
    int            n_age;
    bit            fin, tmo, start;
    if (reset) begin
      m_inpr = '0; m_outr = '0; m_fgi = 0; m_fgo = 1; m_ien = 0;
      m_irq = 0; m_err = 0; m_send = 0; m_age = 0;
      return;
    end
    n_inpr = m_inpr; n_outr = m_outr; n_fgi = m_fgi; n_fgo = m_fgo;
    n_ien = m_ien; n_irq = m_irq; n_err = m_err; n_send = m_send; n_age = m_age;
    fin = 0; tmo = 0; start = 0;
    if (in_valid && !m_fgi) begin
      n_inpr = in_data; n_fgi = 1;
    end else if (rFI) begin
      n_fgi = 0;
    end
    if (sFO) begin
      n_send = 0;
    end else if (m_send) begin
      if (out_ack) fin = 1;
      else if (m_age + 1 == TMO) begin fin = 1; tmo = 1; end
      else n_age = m_age + 1;
      if (fin) n_send = 0;
    end else if (io_out) begin
      start = 1; n_send = 1; n_age = 0; n_outr = io_wdata;
    end
    if (rFO) n_fgo = 0;
    else if (sFO || fin) n_fgo = 1;
    else if (start) n_fgo = 0;
    if (tmo) n_err = 1;
    else if (rFO) n_err = 0;
    if (IRQ_ON) begin
      if (irq_ack || IOF) n_ien = 0;
      else if (ION) n_ien = 1;
      if (irq_ack) n_irq = 0;
      else if (m_ien && (m_fgi || m_fgo)) n_irq = 1;
    end
    m_inpr = n_inpr; m_outr = n_outr; m_fgi = n_fgi; m_fgo = n_fgo;
    m_ien = n_ien; m_irq = n_irq; m_err = n_err; m_send = n_send; m_age = n_age;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    reset = 0; rFI = 0; rFO = 0; sFO = 0; ION = 0; IOF = 0; io_in = 0;
    io_out = 0; io_wdata = '0; in_valid = 0; in_data = '0; out_ack = 0; irq_ack = 0;
  endtask

  // Model and DUT both advance on the same edge; outputs sampled 1 after it.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rdata"},   32'(io_rdata),  32'(m_inpr));
    check({tag, ".ready"},   32'(in_ready),  32'(!m_fgi));
    check({tag, ".ovalid"},  32'(out_valid), 32'(m_send));
    check({tag, ".odata"},   32'(out_data),  32'(m_outr));
    check({tag, ".FGI"},     32'(FGI),       32'(m_fgi));
    check({tag, ".FGO"},     32'(FGO),       32'(m_fgo));
    check({tag, ".IEN"},     32'(IEN),       32'(m_ien));
    check({tag, ".irq"},     32'(irq),       32'(m_irq));
    check({tag, ".err"},     32'(out_err),   32'(m_err));
  endtask

  task automatic chk_irq(input string tag, input logic ien_e, input logic irq_e);
    check({tag, ".IEN"}, 32'(IEN), 32'(ien_e));
    check({tag, ".irq"}, 32'(irq), 32'(irq_e));
  endtask

  // ctl = {reset, rFI, rFO, sFO, io_out, in_valid, out_ack}
  // exp = {FGI, FGO, out_valid, out_err}
  typedef struct {
    logic [6:0]    ctl;
    logic [DW-1:0] wd;
    logic [DW-1:0] id;
    logic [3:0]    exp;
    logic [DW-1:0] e_od;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t vt[24];

  initial begin
    clear_inputs();
    // reset and input accept / refuse / rFI
    vt[0]  = '{7'b1000000, 8'h00, 8'h00, 4'b0100, 8'h00, 8'h00};
    vt[1]  = '{7'b0000010, 8'h00, 8'h5A, 4'b1100, 8'h00, 8'h5A};
    vt[2]  = '{7'b0000010, 8'h00, 8'h33, 4'b1100, 8'h00, 8'h5A};
    vt[3]  = '{7'b0100000, 8'h00, 8'h00, 4'b0100, 8'h00, 8'h5A};
    // output handshake, ack 3 cycles after out_valid rises
    vt[4]  = '{7'b0000100, 8'hC3, 8'h00, 4'b0010, 8'hC3, 8'h5A};
    vt[5]  = '{7'b0000000, 8'h00, 8'h00, 4'b0010, 8'hC3, 8'h5A};
    vt[6]  = '{7'b0000000, 8'h00, 8'h00, 4'b0010, 8'hC3, 8'h5A};
    vt[7]  = '{7'b0000001, 8'h00, 8'h00, 4'b0100, 8'hC3, 8'h5A};
    // timeout after exactly 4 valid cycles, then rFO
    vt[8]  = '{7'b0000100, 8'hA5, 8'h00, 4'b0010, 8'hA5, 8'h5A};
    vt[9]  = '{7'b0000000, 8'h00, 8'h00, 4'b0010, 8'hA5, 8'h5A};
    vt[10] = '{7'b0000000, 8'h00, 8'h00, 4'b0010, 8'hA5, 8'h5A};
    vt[11] = '{7'b0000000, 8'h00, 8'h00, 4'b0010, 8'hA5, 8'h5A};
    vt[12] = '{7'b0000000, 8'h00, 8'h00, 4'b0101, 8'hA5, 8'h5A};
    vt[13] = '{7'b0010000, 8'h00, 8'h00, 4'b0000, 8'hA5, 8'h5A};
    // simultaneous rFI+accept, rFO+ack
    vt[14] = '{7'b0100010, 8'h00, 8'h11, 4'b1000, 8'hA5, 8'h11};
    vt[15] = '{7'b0000100, 8'h7E, 8'h00, 4'b1010, 8'h7E, 8'h11};
    vt[16] = '{7'b0010001, 8'h00, 8'h00, 4'b1000, 8'h7E, 8'h11};
    // reset during SEND
    vt[17] = '{7'b0000100, 8'h3C, 8'h00, 4'b1010, 8'h3C, 8'h11};
    vt[18] = '{7'b1000000, 8'h00, 8'h00, 4'b0100, 8'h00, 8'h00};
    // sFO abort, io_out ignored while sending
    vt[19] = '{7'b0000100, 8'h99, 8'h00, 4'b0010, 8'h99, 8'h00};
    vt[20] = '{7'b0001000, 8'h00, 8'h00, 4'b0100, 8'h99, 8'h00};
    vt[21] = '{7'b0000100, 8'h44, 8'h00, 4'b0010, 8'h44, 8'h00};
    vt[22] = '{7'b0000100, 8'h55, 8'h00, 4'b0010, 8'h44, 8'h00};
    vt[23] = '{7'b0000001, 8'h00, 8'h00, 4'b0100, 8'h44, 8'h00};

    @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      clear_inputs();
      {reset, rFI, rFO, sFO, io_out, in_valid, out_ack} = vt[i].ctl;
      io_wdata = vt[i].wd;
      in_data  = vt[i].id;
      cycle();
      check($sformatf("v%0d.FGI", i),    32'(FGI),       32'(vt[i].exp[3]));
      check($sformatf("v%0d.ready", i),  32'(in_ready),  32'(!vt[i].exp[3]));
      check($sformatf("v%0d.FGO", i),    32'(FGO),       32'(vt[i].exp[2]));
      check($sformatf("v%0d.ovalid", i), 32'(out_valid), 32'(vt[i].exp[1]));
      check($sformatf("v%0d.err", i),    32'(out_err),   32'(vt[i].exp[0]));
      check($sformatf("v%0d.odata", i),  32'(out_data),  32'(vt[i].e_od));
      check($sformatf("v%0d.rdata", i),  32'(io_rdata),  32'(vt[i].e_rd));
      check($sformatf("v%0d.irq", i),    32'(irq),       32'd0);
    end

    // Interrupt sequence (FGO cleared first so FGI alone raises irq)
    clear_inputs(); reset = 1; cycle();
    chk_irq("irq_rst", 1'b0, 1'b0);
    clear_inputs(); rFO = 1; cycle();
    check("irq_rfo.FGO", 32'(FGO), 32'd0);
    clear_inputs(); ION = 1; cycle();
    chk_irq("irq_ion", IRQ_ON, 1'b0);
    clear_inputs(); cycle();
    chk_irq("irq_noflag", IRQ_ON, 1'b0);
    clear_inputs(); in_valid = 1; in_data = 8'h01; cycle();
    check("irq_acc.FGI", 32'(FGI), 32'd1);
    check("irq_acc.rdata", 32'(io_rdata), 32'h01);
    chk_irq("irq_acc", IRQ_ON, 1'b0);
    clear_inputs(); cycle();
    chk_irq("irq_rise", IRQ_ON, IRQ_ON);
    clear_inputs(); rFI = 1; cycle();
    check("irq_rfi.FGI", 32'(FGI), 32'd0);
    chk_irq("irq_hold", IRQ_ON, IRQ_ON);
    clear_inputs(); irq_ack = 1; cycle();
    chk_irq("irq_ack", 1'b0, 1'b0);
    clear_inputs(); ION = 1; IOF = 1; cycle();
    chk_irq("ion_iof", 1'b0, 1'b0);
    clear_inputs(); ION = 1; irq_ack = 1; cycle();
    chk_irq("ion_ack", 1'b0, 1'b0);
    clear_inputs(); ION = 1; cycle();
    chk_irq("ion_again", IRQ_ON, 1'b0);
    check_model("post_irq");

    // Randomized strobes against the model
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 99) == 0);
      rFI      = ($urandom_range(0, 9) == 0);
      rFO      = ($urandom_range(0, 19) == 0);
      sFO      = ($urandom_range(0, 29) == 0);
      ION      = ($urandom_range(0, 7) == 0);
      IOF      = ($urandom_range(0, 15) == 0);
      irq_ack  = ($urandom_range(0, 7) == 0);
      io_in    = ($urandom_range(0, 3) == 0);
      io_out   = ($urandom_range(0, 3) == 0);
      io_wdata = 8'($urandom);
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = 8'($urandom);
      out_ack  = ($urandom_range(0, 5) == 0);
      cycle();
      check_model($sformatf("rnd%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/io_flag_unit.md
# io_flag_unit

Programmed-I/O responder for the single-cycle CPU. It consumes the flag and interrupt control strobes emitted by the instruction decoder (`rFI`, `rFO`, `sFO`, `ION`, `IOF`, plus the IN/OUT instruction strobes). It owns the input/output data registers, the FGI/FGO flags and the interrupt-enable state, and runs the valid/ack handshakes with the external input and output devices. It sits beside the register file and raises `irq` toward the PC logic.

## Interface
- `DATA_W`, 8: width of the input and output data registers.
- `OUT_TIMEOUT`, 255: maximum cycles `out_valid` is held waiting for `out_ack` (1..65535).

Ports:
- `clk` in 1: the single clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rFI`, `rFO`, `sFO`, `ION`, `IOF` in 1 each: decoder strobes, each valid for one cycle.
- `io_in` in 1: IN instruction executing; read `inpr`.
- `io_out` in 1: OUT instruction executing; write `io_wdata`.
- `io_wdata` in DATA_W: data for OUT.
- `io_rdata` out DATA_W: combinational copy of `inpr`.
- `in_valid` in 1, `in_data` in DATA_W: input device offers a byte.
- `in_ready` out 1: equals `!FGI`.
- `out_valid` out 1, `out_data` out DATA_W, `out_ack` in 1: output device handshake.
- `FGI`, `FGO`, `IEN` out 1 each: flag state.
- `irq` out 1: registered interrupt request.
- `irq_ack` in 1: PC logic has taken the interrupt.
- `out_err` out 1: sticky output-timeout flag.

## Operation
- **Reset values:** `inpr`=0, `outr`=0, `FGI`=0, `FGO`=1, `IEN`=0, `irq`=0, `out_err`=0, `out_valid`=0, output FSM in IDLE, timeout counter 0.
- **Input path:**
  - `in_valid & !FGI`: `inpr <= in_data`, `FGI <= 1`.
  - `in_valid` while `FGI`=1: the byte is not accepted and the device holds it.
  - `rFI`: `FGI <= 0`. If `rFI` and an accepting `in_valid` occur in the same cycle, the accept wins and `FGI` ends at 1.
  - `io_in` does not change `FGI`.
- **Output FSM, IDLE:**
  - `io_out`: `outr <= io_wdata`, `FGO <= 0`, counter <= 0, go to SEND.
  - `io_out` in SEND is ignored; software is expected to poll `FGO`.
- **Output FSM, SEND:**
  - `out_valid`=1.
  - `out_ack`: `FGO <= 1`, go to IDLE.
  - Counter reaches `OUT_TIMEOUT-1` with no ack: `out_err <= 1`, `FGO <= 1`, go to IDLE.
  - `out_err` clears only on `reset` or `rFO`.
- **Flag strobes:**
  - `sFO`: `FGO <= 1` and force IDLE (aborts SEND).
  - `rFO`: `FGO <= 0` and `out_err <= 0`; FSM state is unchanged.
  - If `out_ack` and `rFO` coincide, `rFO` wins for `FGO`.
- **Interrupts:**
  - `ION`: `IEN <= 1`. `IOF`: `IEN <= 0`. If both are asserted, `IOF` wins.
  - `irq <= 1` when `IEN & (FGI | FGO) & !irq`.
  - `irq_ack`: `irq <= 0` and `IEN <= 0`. `irq_ack` has priority over `ION` in the same cycle.

## Timing
- Input accept to `FGI`=1: 1 cycle. `in_ready` drops in the cycle after the accept.
- `io_out` to `out_valid`=1: 1 cycle.
- `out_ack` to `FGO`=1: 1 cycle, and `out_valid`=0 in that same cycle. Ack in the first SEND cycle is legal.
- `out_data` equals `outr` and is stable for the whole of SEND.
- `irq` rises 1 cycle after its condition is true. It stays high until `irq_ack`, independent of the flags.
- `reset` mid-SEND: `out_valid` is 0 in the next cycle and the pending byte is dropped.

## Configuration
- **`IO_IRQ_EN` defined:** interrupt logic as above.
- **`IO_IRQ_EN` undefined:**
  - `IEN` and `irq` are tied to 0.
  - `ION`, `IOF` and `irq_ack` are ignored.
  - All flag and handshake behaviour is unchanged.

## Structure
- The shared package `io_pkg` holds:
  - the output FSM state enum (`IO_IDLE`, `IO_SEND`);
  - the default `DATA_W`;
  - the default `OUT_TIMEOUT` constant.
- One sub-module, `io_out_fsm`, contains the output FSM, the timeout counter and `out_err`. It exports `fgo_set` and `fgo_clr` pulses to the top, which owns the `FGO` register and strobe priority.

## Test plan
- **Input accept:** after reset, `in_valid`=1, `in_data`=8'h5A → next cycle `FGI`=1, `in_ready`=0, `io_rdata`=8'h5A. A second offer of 8'h33 is refused and `inpr` stays 8'h5A. Then `rFI` → `FGI`=0.
- **Output handshake:** `io_out` with 8'hC3 → next cycle `out_valid`=1, `out_data`=8'hC3, `FGO`=0. Drive `out_ack` 3 cycles later → next cycle `out_valid`=0, `FGO`=1.
- **Output timeout:** `OUT_TIMEOUT`=4, `io_out`, never ack → `out_valid` high exactly 4 cycles, then `out_err`=1, `FGO`=1. Then `rFO` → `out_err`=0, `FGO`=0.
- **Interrupt:** `ION`, then accept byte 8'h01 → `irq`=1 one cycle after `FGI`=1. Then `irq_ack` → `irq`=0, `IEN`=0. `ION` and `IOF` together → `IEN`=0.
- **Simultaneous events:** `rFI` with accepting `in_valid` → `FGI`=1. `rFO` with `out_ack` → `FGO`=0.
- **Reset in SEND:** `reset` during SEND → all outputs at their reset values next cycle, including `FGO`=1. Repeat with `IO_IRQ_EN` undefined: `irq` stays 0 throughout.
